decode_queue: RTL and testbench
===============================

Name: decode_queue

Overview:
- Parametrised instruction decode stage that sits between fetch and the ID/EX register.
- Decodes each incoming RV32I instruction on enqueue, with optional RV32M. Also detects illegal encodings and distinguishes ECALL from EBREAK.
- Holds the decoded records in a DEPTH-entry FIFO with valid/ready handshakes on both sides.
- A pipeline flush from branch resolution empties the FIFO.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, ≥2.
- XLEN, 32, PC and instruction width.
- EN_M_EXT, 1, 1 decodes funct7=0x01 R-type as MUL/DIV family; 0 makes those encodings illegal.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  discard all queued entries.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  queue can accept; equals (count < DEPTH); no combinational path from out_ready.
- in_inst  in  XLEN  raw instruction.
- in_pc  in  XLEN  instruction PC.
- out_valid  out  1  head entry valid (count != 0).
- out_ready  in  1  downstream accepts head.
- out_inst  out  XLEN  head raw instruction.
- out_pc  out  XLEN  head PC.
- out_ctrl  out  CTRL_W  packed {EX_ctrl, MEM_ctrl, WB_ctrl} of head.
- out_branch, out_predict, out_ujtype  out  1 each  head flags.
- out_excp  out  1  head raises exception.
- out_cause  out  2  0 none, 1 ECALL, 2 EBREAK, 3 ILLEGAL.
- count  out  $clog2(DEPTH+1)  occupancy.

Behaviour:
- Reset: pointers, count, all storage and every out_* port are 0. in_ready is 1 once rst deasserts.
- Push when in_valid & in_ready. The entry is decoded combinationally from in_inst and written to the tail.
- Latency: an entry pushed in cycle N appears at out_* in cycle N+1. There is no bypass when empty.
- Pop when out_valid & out_ready. The head advances and the next entry is visible the following cycle.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- When full, in_ready=0. A pop in the full cycle frees space only from the next cycle.
- Pointers wrap modulo DEPTH.
- flush: next cycle count=0, pointers=0, out_valid=0. Flush dominates a same-cycle push or pop; the pushed instruction is dropped. Stored data is not cleared.
- When out_valid=0, out_* fields are don't-care, but the bench treats out_excp=0 as required.
- Async rst mid-operation clears everything immediately, regardless of clk.
- Decode is the standard RV32I table: R, I-arith, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM.
  - ALUSrc encoding: 0 reg, 1 imm, 2 PC+4 link, 3 PC.
  - BRANCH sets branch=1 and predict=1. JAL sets ujtype=1.
- SYSTEM decode:
  - inst=0x00000073 gives cause 1.
  - inst=0x00100073 gives cause 2.
  - Other SYSTEM encodings are illegal.
- Illegal (cause 3), all other ctrl zero, RegWrite=0:
  - unknown opcode;
  - LOAD funct3 in {3,6,7};
  - STORE funct3 ≥3;
  - BRANCH funct3 in {2,3};
  - R-type funct7 not in {0x00, 0x20 (ADD/SRL funct3 only), 0x01 (EN_M_EXT only)};
  - shift-immediate funct7 not 0x00 (SLLI/SRLI) or 0x00/0x20 (SRLI/SRAI);
  - JALR funct3 ≠ 0;
  - inst[1:0] ≠ 2'b11.
- Any exception sets excp=1 and zeroes MemWrite, MemRead, RegWrite and branch.
- M-ext funct3 0..7 maps to ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode/funct3/funct7 constants;
  - ALU op codes, widened to 5 bits for the M ops;
  - BRU op codes, LDST codes and cause encodings;
  - CTRL_W;
  - typedef struct packed dec_rec_t {ctrl, branch, predict, ujtype, excp, cause}.
- One combinational sub-module, inst_decoder (inst → dec_rec_t, parameter EN_M_EXT), instantiated once on the enqueue path.
- decode_queue holds the FIFO and handshake logic.

Test Plan:
- Reset, then push 0x002081B3 (add x3,x1,x2). Next cycle: out_valid=1, out_ctrl ALUOp=ALU_ADD, ALUSrc=0, RegWrite=1, out_excp=0, count=1.
- With out_ready=0, push 5 instructions, DEPTH=4. in_ready drops after the 4th push and the 5th is not accepted. Raise out_ready: pops return PCs in push order, count returns to 0.
- EN_M_EXT=1: 0x022081B3 gives ALU_MUL, excp=0. EN_M_EXT=0: same inst gives out_excp=1, out_cause=3, RegWrite=0.
- Push 0x00000073, 0x00100073, 0xFFFFFFFF, 0x0000B283 (funct3=3 load). Causes are 1, 2, 3, 3 respectively.
- Queue 3 entries, assert flush with in_valid=1 the same cycle. Next cycle count=0, out_valid=0, and the flushed-cycle instruction never appears.
- Continuous push and pop at full throughput for 20 cycles with DEPTH=4 (pointer wrap). Every instruction emerges exactly once, in order, with count stable at 1.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: RV32IM decode constants, control record layout and cause codes
package ctrl_pkg;
   localparam logic [6:0] OP_R      = 7'h33;
   localparam logic [6:0] OP_I      = 7'h13;
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_JAL    = 7'h6f;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_AUIPC  = 7'h17;
   localparam logic [6:0] OP_SYSTEM = 7'h73;
   localparam logic [6:0] F7_BASE = 7'h00;
   localparam logic [6:0] F7_ALT  = 7'h20;
   localparam logic [6:0] F7_M    = 7'h01;
   localparam logic [2:0] F3_ADD = 3'd0;
   localparam logic [2:0] F3_SLL = 3'd1;
   localparam logic [2:0] F3_SR  = 3'd5;
   localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
   typedef enum logic [4:0] {
      ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_SLL = 5'd2, ALU_SLT = 5'd3, ALU_SLTU = 5'd4,
      ALU_XOR = 5'd5, ALU_SRL = 5'd6, ALU_SRA = 5'd7, ALU_OR = 5'd8, ALU_AND = 5'd9,
      ALU_PASSB = 5'd10,
      ALU_MUL = 5'd16, ALU_MULH = 5'd17, ALU_MULHSU = 5'd18, ALU_MULHU = 5'd19,
      ALU_DIV = 5'd20, ALU_DIVU = 5'd21, ALU_REM = 5'd22, ALU_REMU = 5'd23
   } alu_op_t;
   typedef enum logic [1:0] {SRC_REG, SRC_IMM, SRC_LINK, SRC_PC} alu_src_t;
   // Branch compares reuse funct3 directly; the two unused funct3 slots carry jumps
   localparam logic [2:0] BRU_JAL  = 3'd2;
   localparam logic [2:0] BRU_JALR = 3'd3;
   typedef enum logic [1:0] {CAUSE_NONE, CAUSE_ECALL, CAUSE_EBREAK, CAUSE_ILLEGAL} cause_t;
   typedef struct packed {
      alu_op_t    alu_op;
      alu_src_t   alu_src;
      logic [2:0] bru_op;
   } ex_ctrl_t;
   typedef struct packed {
      logic       mem_read;
      logic       mem_write;
      logic [2:0] ldst;
   } mem_ctrl_t;
   typedef struct packed {
      logic reg_write;
      logic mem_to_reg;
   } wb_ctrl_t;
   typedef struct packed {
      ex_ctrl_t  ex;
      mem_ctrl_t mem;
      wb_ctrl_t  wb;
   } ctrl_t;
   localparam int CTRL_W = $bits(ctrl_t);
   typedef struct packed {
      ctrl_t  ctrl;
      logic   branch;
      logic   predict;
      logic   ujtype;
      logic   excp;
      cause_t cause;
   } dec_rec_t;
   function automatic alu_op_t alu_base(input logic [2:0] f3, input logic alt);
      case (f3)
         3'd0: return alt ? ALU_SUB : ALU_ADD;
         3'd1: return ALU_SLL;
         3'd2: return ALU_SLT;
         3'd3: return ALU_SLTU;
         3'd4: return ALU_XOR;
         3'd5: return alt ? ALU_SRA : ALU_SRL;
         3'd6: return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction
endpackage

// File: rtl/inst_decoder.sv
// inst_decoder: combinational RV32I(+M) decode into a control record with exception cause
module inst_decoder import ctrl_pkg::*; #(
   parameter bit EN_M_EXT = 1'b1
) (
   input  logic [31:0] inst,
   output dec_rec_t    rec
);
   logic [6:0] op, f7;
   logic [2:0] f3;
   ctrl_t      c;
   logic       ill, br, uj;
   cause_t     cause;
   assign op = inst[6:0];
   assign f3 = inst[14:12];
   assign f7 = inst[31:25];
   always_comb begin
      c = '0;
      ill = 1'b0;
      br = 1'b0;
      uj = 1'b0;
      cause = CAUSE_NONE;
      case (op)
         OP_R: begin
            c.ex.alu_op = f7 == F7_M ? alu_op_t'({2'b10, f3}) : alu_base(f3, f7 == F7_ALT);
            c.wb.reg_write = 1'b1;
            ill = !(f7 == F7_BASE || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR)) || (f7 == F7_M && EN_M_EXT));
         end
         OP_I: begin
            c.ex.alu_op = alu_base(f3, f3 == F3_SR && f7 == F7_ALT);
            c.ex.alu_src = SRC_IMM;
            c.wb.reg_write = 1'b1;
            ill = (f3 == F3_SLL && f7 != F7_BASE) || (f3 == F3_SR && f7 != F7_BASE && f7 != F7_ALT);
         end
         OP_LOAD: begin
            c.ex.alu_src = SRC_IMM;
            c.mem.mem_read = 1'b1;
            c.mem.ldst = f3;
            c.wb.reg_write = 1'b1;
            c.wb.mem_to_reg = 1'b1;
            ill = f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7;
         end
         OP_STORE: begin
            c.ex.alu_src = SRC_IMM;
            c.mem.mem_write = 1'b1;
            c.mem.ldst = f3;
            ill = f3 > 3'd2;
         end
         OP_BRANCH: begin
            c.ex.alu_op = ALU_SUB;
            c.ex.bru_op = f3;
            br = 1'b1;
            ill = f3 == 3'd2 || f3 == 3'd3;
         end
         OP_JAL: begin
            c.ex.alu_src = SRC_LINK;
            c.ex.bru_op = BRU_JAL;
            c.wb.reg_write = 1'b1;
            uj = 1'b1;
         end
         OP_JALR: begin
            c.ex.alu_src = SRC_LINK;
            c.ex.bru_op = BRU_JALR;
            c.wb.reg_write = 1'b1;
            ill = f3 != 3'd0;
         end
         OP_LUI: begin
            c.ex.alu_op = ALU_PASSB;
            c.ex.alu_src = SRC_IMM;
            c.wb.reg_write = 1'b1;
         end
         OP_AUIPC: begin
            c.ex.alu_src = SRC_PC;
            c.wb.reg_write = 1'b1;
         end
         OP_SYSTEM: cause = inst == INST_ECALL ? CAUSE_ECALL : inst == INST_EBREAK ? CAUSE_EBREAK : CAUSE_ILLEGAL;
         default: ill = 1'b1;
      endcase
      // Any trapping instruction must leave no side effects downstream
      rec.cause = ill ? CAUSE_ILLEGAL : cause;
      rec.excp = rec.cause != CAUSE_NONE;
      rec.ctrl = rec.excp ? '0 : c;
      rec.branch = br & ~rec.excp;
      rec.predict = br & ~rec.excp;
      rec.ujtype = uj & ~rec.excp;
   end
endmodule

// File: rtl/decode_queue.sv
// decode_queue: decode-on-enqueue FIFO between fetch and ID/EX with flush
module decode_queue import ctrl_pkg::*; #(
   parameter int DEPTH    = 4,
   parameter int XLEN     = 32,
   parameter bit EN_M_EXT = 1'b1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [XLEN-1:0]              in_inst,
   input  logic [XLEN-1:0]              in_pc,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [XLEN-1:0]              out_inst,
   output logic [XLEN-1:0]              out_pc,
   output logic [CTRL_W-1:0]            out_ctrl,
   output logic                         out_branch,
   output logic                         out_predict,
   output logic                         out_ujtype,
   output logic                         out_excp,
   output logic [1:0]                   out_cause,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   typedef struct packed {
      logic [XLEN-1:0] inst;
      logic [XLEN-1:0] pc;
      dec_rec_t        rec;
   } entry_t;
   entry_t          mem [DEPTH];
   entry_t          head;
   dec_rec_t        dec;
   logic [AW-1:0]   wp, rp;
   logic            push, pop;
   inst_decoder #(.EN_M_EXT(EN_M_EXT)) u_dec (.inst(in_inst[31:0]), .rec(dec));
   assign in_ready = count < CW'(DEPTH);
   assign out_valid = count != '0;
   assign push = in_valid & in_ready;
   assign pop = out_valid & out_ready;
   assign head = mem[rp];
   assign out_inst = head.inst;
   assign out_pc = head.pc;
   assign out_ctrl = head.rec.ctrl;
   assign out_branch = head.rec.branch;
   assign out_predict = head.rec.predict;
   assign out_ujtype = head.rec.ujtype;
   // Stale entries survive a flush, so the trap flag is qualified by occupancy
   assign out_excp = out_valid & head.rec.excp;
   assign out_cause = out_valid ? head.rec.cause : CAUSE_NONE;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp <= '0;
         rp <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wp <= '0;
         rp <= '0;
         count <= '0;
      end else begin
         if (push) begin
            mem[wp] <= '{inst: in_inst, pc: in_pc, rec: dec};
            wp <= wp + 1'b1;
         end
         if (pop) rp <= rp + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: random and directed checks of decode_queue against a queue-based model
module tb_decode_queue;
   import ctrl_pkg::*;
   localparam int DEPTH = 4;
   logic clk = 1'b0, rst, flush, in_valid, out_ready;
   logic [31:0] in_inst, in_pc, pc;
   logic ir[2], ov[2], obr[2], opr[2], ouj[2], oex[2];
   logic [31:0] oi[2], opc[2];
   logic [CTRL_W-1:0] oc[2];
   logic [1:0] oca[2];
   logic [2:0] cnt[2];
   int checks = 0, errors = 0;
   typedef struct {logic [31:0] inst; logic [31:0] pc;} item_t;
   item_t q[$];
   always #5 clk = ~clk;
   decode_queue #(.DEPTH(DEPTH), .XLEN(32), .EN_M_EXT(1'b1)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
      .in_inst(in_inst), .in_pc(in_pc), .out_valid(ov[0]), .out_ready(out_ready),
      .out_inst(oi[0]), .out_pc(opc[0]), .out_ctrl(oc[0]), .out_branch(obr[0]),
      .out_predict(opr[0]), .out_ujtype(ouj[0]), .out_excp(oex[0]), .out_cause(oca[0]), .count(cnt[0]));
   decode_queue #(.DEPTH(DEPTH), .XLEN(32), .EN_M_EXT(1'b0)) dut_nom (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
      .in_inst(in_inst), .in_pc(in_pc), .out_valid(ov[1]), .out_ready(out_ready),
      .out_inst(oi[1]), .out_pc(opc[1]), .out_ctrl(oc[1]), .out_branch(obr[1]),
      .out_predict(opr[1]), .out_ujtype(ouj[1]), .out_excp(oex[1]), .out_cause(oca[1]), .count(cnt[1]));
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic ctrl_t ctl(input int k);
      return ctrl_t'(oc[k]);
   endfunction
   // Reference decode written as a legality table first, then the field assignments
   function automatic dec_rec_t ref_dec(input logic [31:0] i, input bit en_m);
      dec_rec_t r;
      logic [6:0] op;
      logic [6:0] f7;
      logic [2:0] f3;
      bit ok;
      alu_op_t base[8];
      base = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
      op = i[6:0];
      f3 = i[14:12];
      f7 = i[31:25];
      r = '0;
      ok = 1;
      case (op)
         7'h33: begin
            ok = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)) || (f7 == 7'h01 && en_m);
            r.ctrl.wb.reg_write = 1;
            if (f7 == 7'h01) r.ctrl.ex.alu_op = alu_op_t'(5'(16 + int'(f3)));
            else if (f7 == 7'h20) r.ctrl.ex.alu_op = (f3 == 0) ? ALU_SUB : ALU_SRA;
            else r.ctrl.ex.alu_op = base[f3];
         end
         7'h13: begin
            if (f3 == 1) ok = f7 == 0;
            if (f3 == 5) ok = f7 == 0 || f7 == 7'h20;
            r.ctrl.ex.alu_op = (f3 == 5 && f7 == 7'h20) ? ALU_SRA : base[f3];
            r.ctrl.ex.alu_src = SRC_IMM;
            r.ctrl.wb.reg_write = 1;
         end
         7'h03: begin
            ok = f3 inside {0, 1, 2, 4, 5};
            r.ctrl.ex.alu_src = SRC_IMM;
            r.ctrl.mem.mem_read = 1;
            r.ctrl.mem.ldst = f3;
            r.ctrl.wb = '{reg_write: 1'b1, mem_to_reg: 1'b1};
         end
         7'h23: begin
            ok = f3 < 3;
            r.ctrl.ex.alu_src = SRC_IMM;
            r.ctrl.mem.mem_write = 1;
            r.ctrl.mem.ldst = f3;
         end
         7'h63: begin
            ok = !(f3 inside {2, 3});
            r.ctrl.ex.alu_op = ALU_SUB;
            r.ctrl.ex.bru_op = f3;
            r.branch = 1;
            r.predict = 1;
         end
         7'h6f: begin
            r.ctrl.ex.alu_src = SRC_LINK;
            r.ctrl.ex.bru_op = 3'd2;
            r.ctrl.wb.reg_write = 1;
            r.ujtype = 1;
         end
         7'h67: begin
            ok = f3 == 0;
            r.ctrl.ex.alu_src = SRC_LINK;
            r.ctrl.ex.bru_op = 3'd3;
            r.ctrl.wb.reg_write = 1;
         end
         7'h37: begin
            r.ctrl.ex.alu_op = ALU_PASSB;
            r.ctrl.ex.alu_src = SRC_IMM;
            r.ctrl.wb.reg_write = 1;
         end
         7'h17: begin
            r.ctrl.ex.alu_src = SRC_PC;
            r.ctrl.wb.reg_write = 1;
         end
         default: ok = 0;
      endcase
      if (i == 32'h0000_0073 || i == 32'h0010_0073) begin
         r = '0;
         r.excp = 1;
         r.cause = i[20] ? CAUSE_EBREAK : CAUSE_ECALL;
      end else if (!ok) begin
         r = '0;
         r.excp = 1;
         r.cause = CAUSE_ILLEGAL;
      end
      return r;
   endfunction
   task automatic check_outputs();
      dec_rec_t e;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("m%0d_in_ready", k), ir[k], q.size() < DEPTH);
         check($sformatf("m%0d_out_valid", k), ov[k], q.size() != 0);
         check($sformatf("m%0d_count", k), cnt[k], q.size());
         if (q.size() != 0) begin
            e = ref_dec(q[0].inst, k == 0);
            check($sformatf("m%0d_pc", k), opc[k], q[0].pc);
            check($sformatf("m%0d_inst", k), oi[k], q[0].inst);
            check($sformatf("m%0d_ctrl[%h]", k, q[0].inst), oc[k], e.ctrl);
            check($sformatf("m%0d_flags[%h]", k, q[0].inst), {obr[k], opr[k], ouj[k]}, {e.branch, e.predict, e.ujtype});
            check($sformatf("m%0d_excp[%h]", k, q[0].inst), oex[k], e.excp);
            check($sformatf("m%0d_cause[%h]", k, q[0].inst), oca[k], e.cause);
         end else check($sformatf("m%0d_idle_excp", k), oex[k], 0);
      end
   endtask
   task automatic cycle();
      bit pu, po;
      @(negedge clk);
      check_outputs();
      pu = in_valid && q.size() < DEPTH;
      po = q.size() != 0 && out_ready;
      @(posedge clk);
      if (flush) q.delete();
      else begin
         if (po) void'(q.pop_front());
         if (pu) q.push_back('{in_inst, in_pc});
      end
      #1;
   endtask
   task automatic drv(input bit v, input logic [31:0] i, input bit r, input bit f = 1'b0);
      in_valid = v;
      in_inst = i;
      in_pc = pc;
      out_ready = r;
      flush = f;
      pc += 4;
      cycle();
   endtask
   function automatic logic [31:0] rnd_inst();
      logic [31:0] r;
      logic [6:0] ops[10];
      int sel;
      ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h73};
      r = $urandom;
      sel = $urandom_range(0, 12);
      if (sel == 10) return $urandom_range(0, 1) ? 32'h0000_0073 : 32'h0010_0073;
      if (sel < 10) r[6:0] = ops[sel];
      case ($urandom_range(0, 3))
         0: r[31:25] = 7'h00;
         1: r[31:25] = 7'h20;
         2: r[31:25] = 7'h01;
         default: ;
      endcase
      return r;
   endfunction
   initial begin
      logic [31:0] sys[4];
      logic [1:0] sys_cause[4];
      sys = '{32'h0000_0073, 32'h0010_0073, 32'hFFFF_FFFF, 32'h0000_B283};
      sys_cause = '{2'd1, 2'd2, 2'd3, 2'd3};
      rst = 1;
      flush = 0;
      in_valid = 0;
      out_ready = 0;
      in_inst = 0;
      in_pc = 0;
      pc = 32'h1000;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         check("rst_valid", ov[k], 0);
         check("rst_count", cnt[k], 0);
         check("rst_pc", opc[k], 0);
         check("rst_inst", oi[k], 0);
         check("rst_ctrl", oc[k], 0);
         check("rst_cause", {oex[k], oca[k]}, 0);
      end
      @(posedge clk);
      #1 rst = 0;
      drv(1, 32'h002081B3, 0);
      check("add_alu", ctl(0).ex.alu_op, ALU_ADD);
      check("add_src", ctl(0).ex.alu_src, SRC_REG);
      check("add_rw", ctl(0).wb.reg_write, 1);
      check("add_excp", oex[0], 0);
      check("add_count", cnt[0], 1);
      drv(0, 0, 1);
      for (int n = 0; n < 5; n++) begin
         drv(1, rnd_inst(), 0);
         if (n == 3) check("full_ready", ir[0], 0);
      end
      check("full_count", cnt[0], 4);
      repeat (5) drv(0, 0, 1);
      check("drain_count", cnt[0], 0);
      drv(1, 32'h022081B3, 0);
      check("mul_alu", ctl(0).ex.alu_op, ALU_MUL);
      check("mul_excp", oex[0], 0);
      check("nom_excp", oex[1], 1);
      check("nom_cause", oca[1], 3);
      check("nom_rw", ctl(1).wb.reg_write, 0);
      drv(0, 0, 1);
      for (int n = 0; n < 4; n++) drv(1, sys[n], 0);
      for (int n = 0; n < 4; n++) begin
         check($sformatf("sys_cause%0d", n), oca[0], sys_cause[n]);
         drv(0, 0, 1);
      end
      for (int n = 0; n < 3; n++) drv(1, rnd_inst(), 0);
      drv(1, 32'h00500093, 0, 1);
      check("flush_count", cnt[0], 0);
      check("flush_valid", ov[0], 0);
      repeat (2) drv(0, 0, 1);
      for (int n = 0; n < 21; n++) begin
         drv(1, rnd_inst(), 1);
         if (n > 0) check("tput_count", cnt[0], 1);
      end
      drv(0, 0, 1);
      repeat (400) drv($urandom_range(0, 3) != 0, rnd_inst(), $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
      for (int n = 0; n < 3; n++) drv(1, rnd_inst(), 0);
      #1 rst = 1;
      #1;
      check("arst_count", cnt[0], 0);
      check("arst_valid", ov[0], 0);
      check("arst_pc", opc[0], 0);
      #1 rst = 0;
      q.delete();
      in_valid = 0;
      repeat (3) drv(1, rnd_inst(), 1);
      drv(0, 0, 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
